decoder_pipe_nx2n: RTL

//  Multi-channel, parametrised N-to-2^N decoder with a valid/ready stream interface.

---
 rtl/decoder_pipe_nx2n.sv | 124 ++++++++++++
 1 files changed

// File: rtl/decoder_pipe_nx2n.sv
// Multi-lane N-to-2^N decoder (one-hot or thermometer) behind a 2-entry
// skid buffer with valid/ready handshakes and a saturating delivery counter.

// One lane: decodes a SEL_W-bit code into a D-bit word; enable gates the lane.
module decoder_pipe_lane #(
    parameter int SEL_W = 4,
    parameter int MODE  = 0,
    localparam int D    = 2**SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [D-1:0]     word
);
    // Bit k compares its own index against the code: equality for one-hot,
    // less-or-equal for thermometer.
    always_comb begin
        word = '0;
        for (int k = 0; k < D; k++) begin
            if (MODE == 1) word[k] = en && (k <= int'(sel));
            else           word[k] = en && (k == int'(sel));
        end
    end
endmodule

module decoder_pipe_nx2n #(
    parameter int SEL_W    = 4,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    parameter int CNT_W    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CHANNELS*SEL_W-1:0]        decoder_in,
    input  logic [CHANNELS-1:0]              decoder_en,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CHANNELS*(2**SEL_W)-1:0]   decoder_out,
    output logic [CNT_W-1:0]                 decode_count
);
    localparam int D = 2**SEL_W;

    typedef logic [CHANNELS-1:0][D-1:0] word_t;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state, state_nxt;
    word_t  dec_word;
    word_t  head_q, head_nxt;
    word_t  skid_q, skid_nxt;
    logic   accept, xfer;

    // Per-lane decoders; the stored word is the already-decoded result.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        decoder_pipe_lane #(.SEL_W(SEL_W), .MODE(MODE)) u_lane (
            .sel  (decoder_in[c*SEL_W +: SEL_W]),
            .en   (decoder_en[c]),
            .word (dec_word[c])
        );
    end

    assign out_valid   = (state != EMPTY);
    assign accept      = in_valid & in_ready;
    assign xfer        = out_valid & out_ready;
    assign decoder_out = head_q;

    // Skid-buffer next state: head drives the output, skid holds the overflow word.
    always_comb begin
        state_nxt = state;
        head_nxt  = head_q;
        skid_nxt  = skid_q;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    head_nxt  = dec_word;
                end
            end
            ONE: begin
                if (accept && xfer) begin
                    head_nxt = dec_word;
                end else if (accept) begin
                    state_nxt = TWO;
                    skid_nxt  = dec_word;
                end else if (xfer) begin
                    // Clear head so the output reads zero while empty.
                    state_nxt = EMPTY;
                    head_nxt  = '0;
                end
            end
            TWO: begin
                if (xfer) begin
                    state_nxt = ONE;
                    head_nxt  = skid_q;
                end
            end
            default: begin
                state_nxt = EMPTY;
                head_nxt  = '0;
            end
        endcase
    end

    // State and data registers; in_ready is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            head_q   <= '0;
            skid_q   <= '0;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            head_q   <= head_nxt;
            skid_q   <= skid_nxt;
            in_ready <= (state_nxt != TWO);
        end
    end

    // Delivered-word counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              decode_count <= '0;
        else if (xfer && (decode_count != '1))   decode_count <= decode_count + CNT_W'(1);
    end
endmodule
